// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, fixed opcodes and the IR capture pattern.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    // Opcodes are cast down to IR_W at the point of use; all-ones truncates to all-ones.
    localparam logic [31:0] OP_BYPASS    = 32'hFFFF_FFFF;
    localparam logic [31:0] OP_IDCODE    = 32'd1;
    localparam int          OP_USER_BASE = 2;
    localparam logic [1:0]  IR_CAPTURE   = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with decoded DR strobes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state,
    output tap_state_t nxt,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) state <= TEST_LOGIC_RESET;
        else       state <= nxt;
    end

    always_comb begin
        nxt = TEST_LOGIC_RESET;
        case (state)
            TEST_LOGIC_RESET: nxt = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = TMS ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        nxt = TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       nxt = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         nxt = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         nxt = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         nxt = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         nxt = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        nxt = TMS ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        nxt = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         nxt = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         nxt = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         nxt = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         nxt = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        nxt = TMS ? SELECT_DR : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
    end

    assign capture_dr = (state == CAPTURE_DR);
    assign shift_dr   = (state == SHIFT_DR);
    assign update_dr  = (state == UPDATE_DR);

endmodule

// File: rtl/jtag_tap_param.sv
// JTAG TAP top: instruction register, BYPASS/IDCODE data registers, user-chain select and TDO mux.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          NUM_CHAINS = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic                  TCLK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    input  logic [NUM_CHAINS-1:0] chain_tdo,
    output logic [NUM_CHAINS-1:0] chain_sel,
    output logic                  capture_dr,
    output logic                  shift_dr,
    output logic                  update_dr,
    output logic [3:0]            tap_state
);

    tap_state_t      state;
    tap_state_t      nxt;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_sh;
    logic            bypass;
    logic [31:0]     id_sh;
    logic            sel_idcode;
    logic            sel_user;
    logic            tdo_nxt;

    jtag_tap_fsm u_fsm (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .nxt        (nxt),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign tap_state = state;

    // Loading IDCODE on entry (not one cycle after) keeps IR valid for the whole stay in Test-Logic-Reset.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            ir    <= IR_W'(OP_IDCODE);
            ir_sh <= IR_W'(IR_CAPTURE);
        end else begin
            case (state)
                CAPTURE_IR: ir_sh <= IR_W'(IR_CAPTURE);
                SHIFT_IR:   ir_sh <= {TDI, ir_sh[IR_W-1:1]};
                default:    ;
            endcase
            if (nxt == TEST_LOGIC_RESET) ir <= IR_W'(OP_IDCODE);
            else if (state == UPDATE_IR) ir <= ir_sh;
        end
    end

    assign sel_idcode = (ir == IR_W'(OP_IDCODE));

    // Chains whose opcode would not fit, or would alias the all-ones BYPASS code, are unreachable.
    for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_sel
        if (OP_USER_BASE + k < (1 << IR_W) - 1) begin : g_on
            assign chain_sel[k] = (ir == IR_W'(OP_USER_BASE + k));
        end else begin : g_off
            assign chain_sel[k] = 1'b0;
        end
    end

    assign sel_user = |chain_sel;

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            bypass <= 1'b0;
            id_sh  <= IDCODE_VAL;
        end else if (state == CAPTURE_DR) begin
            bypass <= 1'b0;
            if (sel_idcode) id_sh <= IDCODE_VAL;
        end else if (state == SHIFT_DR) begin
            if (sel_idcode)     id_sh  <= {TDI, id_sh[31:1]};
            else if (!sel_user) bypass <= TDI;
        end
    end

    always_comb begin
        tdo_nxt = 1'b0;
        if (state == SHIFT_IR) begin
            tdo_nxt = ir_sh[0];
        end else if (state == SHIFT_DR) begin
            if (sel_idcode)    tdo_nxt = id_sh[0];
            else if (sel_user) tdo_nxt = |(chain_sel & chain_tdo);
            else               tdo_nxt = bypass;
        end
    end

    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) TDO <= 1'b0;
        else       TDO <= tdo_nxt;
    end

endmodule

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 4, instruction register width (min 2).
REQ-002 Parameter NUM_CHAINS, default 2, number of external user scan chains (1..8).
REQ-003 Parameter IDCODE_VAL, default 32'h1234_5001, IDCODE register contents; bit 0 SHALL be 1.
REQ-004 TCLK  input  1  sole test clock.
REQ-005 TRST  input  1  asynchronous, active-low reset.
REQ-006 TMS  input  1  mode select, sampled on TCLK rising edge.
REQ-007 TDI  input  1  serial data in, sampled on TCLK rising edge.
REQ-008 TDO  output  1  serial data out, changes on TCLK falling edge.
REQ-009 chain_tdo  input  NUM_CHAINS  serial return from each user chain.
REQ-010 chain_sel  output  NUM_CHAINS  one-hot select of the active user chain; all-zero otherwise.
REQ-011 capture_dr, shift_dr, update_dr  output  1 each  DR strobes, each high for the whole cycle the FSM sits in that state.
REQ-012 tap_state  output  4  current FSM state encoding, for debug.

Function
REQ-013 FSM SHALL implement all 16 IEEE 1149.1 TAP states with standard TMS transitions.
REQ-014 Five consecutive TMS=1 edges SHALL reach Test-Logic-Reset from any state.
REQ-015 In Test-Logic-Reset, IR SHALL hold the IDCODE opcode.
REQ-016 Opcodes: all-ones = BYPASS; 1 = IDCODE; 2+k = user chain k (k < NUM_CHAINS); any other opcode = BYPASS.
REQ-017 Capture-IR SHALL load the shift IR with binary ...0001 (LSBs 2'b01, rest 0).
REQ-018 Shift-IR SHALL shift LSB-first from TDI toward TDO; the active IR changes only in Update-IR.
REQ-019 BYPASS: 1-bit register; Capture-DR loads 0; Shift-DR delay TDI->TDO is one TCLK.
REQ-020 IDCODE: 32-bit register; Capture-DR loads IDCODE_VAL; shifted LSB-first.
REQ-021 User chain k: chain_sel[k]=1 whenever the active IR selects k; TDO source in Shift-DR is chain_tdo[k].
REQ-022 TDO SHALL be updated on the TCLK falling edge from the selected register LSB during Shift-IR/Shift-DR; otherwise it holds 0.
REQ-023 The strobes SHALL be high only in their states; update_dr SHALL not assert for IR scans.
REQ-024 Exit1/Pause/Exit2 SHALL hold all shift-register contents unchanged.
REQ-025 An IR update during Shift-DR is impossible by construction; chain_sel SHALL change only at Update-IR or reset.

Reset
REQ-026 TRST low SHALL asynchronously force: state = Test-Logic-Reset, IR = IDCODE opcode, bypass = 0, TDO = 0, all strobes = 0.
REQ-027 chain_sel SHALL be all-zero in reset.
REQ-028 TRST asserted mid-scan SHALL abort the scan with no Update of IR or DR.
REQ-029 Deassertion SHALL take effect at the first TCLK rising edge after TRST rises.

Structure
REQ-030 State encodings, the BYPASS/IDCODE opcode constants and the capture pattern SHALL reside in shared package jtag_pkg.
REQ-031 The 16-state FSM SHALL be a separate sub-module, jtag_tap_fsm; the IR, BYPASS, IDCODE and TDO mux live in the top module.

Verification
REQ-032 TRST pulse, then TMS=0 -> Run-Test-Idle; shift 32 DR bits out -> 32'h1234_5001 LSB-first.
REQ-033 Load IR=4'hF, shift 8'hA5 through DR -> TDO returns 8'hA5 delayed one bit, first bit 0.
REQ-034 IR scan with TDI=0 -> first 4 TDO bits read 1,0,0,0 (capture pattern).
REQ-035 Load IR=4'h3 -> chain_sel=2'b10; 10-bit DR shift drives shift_dr high for exactly 10 cycles and TDO mirrors chain_tdo[1].
REQ-036 Load opcode 4'h7 (unused) -> behaves as BYPASS and chain_sel=0.
REQ-037 Five TMS=1 from Pause-DR, and separately TRST low mid-Shift-IR -> Test-Logic-Reset, IR=IDCODE opcode, no update_dr pulse.
